// File: rtl/dev_bus_pkg.sv
// Shared definitions for the two-master device bus arbiter: FSM state codes,
// the two device address windows and the window hit test.
package dev_bus_pkg;

   localparam logic [1:0] ST_IDLE   = 2'd0;
   localparam logic [1:0] ST_ACCESS = 2'd1;
   localparam logic [1:0] ST_RESP   = 2'd2;

   localparam logic [63:0] WIN0_BASE  = 64'h7F00;
   localparam logic [63:0] WIN0_LIMIT = 64'h7F0B;
   localparam logic [63:0] WIN1_BASE  = 64'h7F10;
   localparam logic [63:0] WIN1_LIMIT = 64'h7F1B;

   // Address is widened to 64 bits by the caller so any ADDR_W up to 64 works.
   function automatic logic addr_hit(input logic [63:0] addr);
      return ((addr >= WIN0_BASE) && (addr <= WIN0_LIMIT)) ||
             ((addr >= WIN1_BASE) && (addr <= WIN1_LIMIT));
   endfunction

endpackage

// File: rtl/dev_bus_rr_pick.sv
// Two-way round-robin picker: the pointed-to master wins if it requests,
// otherwise the other one does.
module dev_bus_rr_pick
   import dev_bus_pkg::*;
(
   input  logic [1:0] req,
   input  logic       ptr,
   output logic       win,
   output logic       any
);

   assign any = |req;
   assign win = req[ptr] ? ptr : ~ptr;

endmodule

// File: rtl/dev_bus_arbiter.sv
// Round-robin arbiter sharing the device bridge bus between CPU (m0) and DMA/debug (m1).
// Optional DEV_BUS_LOCK_EN: a locked master that keeps requesting keeps the next slot.
//
// state  | meaning
// IDLE   | waiting for any m_req; winner and its request are latched on exit
// ACCESS | bridge bus driven; gnt and dev_we on first cycle; BUS_WAIT extra cycles
// RESP   | m_ack/m_rdata/m_err presented for one cycle; round-robin pointer updated
module dev_bus_arbiter
   import dev_bus_pkg::*;
#(
   parameter int ADDR_W   = 32,
   parameter int DATA_W   = 32,
   parameter int BUS_WAIT = 0
)(
   input  logic              clk,
   input  logic              reset_n,
   input  logic [1:0]        m_req,
   input  logic [1:0]        m_we,
   input  logic [ADDR_W-1:0] m0_addr,
   input  logic [ADDR_W-1:0] m1_addr,
   input  logic [DATA_W-1:0] m0_wdata,
   input  logic [DATA_W-1:0] m1_wdata,
   input  logic [1:0]        m_lock,
   output logic [1:0]        m_gnt,
   output logic [1:0]        m_ack,
   output logic [DATA_W-1:0] m_rdata,
   output logic              m_err,
   output logic [ADDR_W-1:0] dev_addr,
   output logic [DATA_W-1:0] dev_wdata,
   output logic              dev_we,
   input  logic [DATA_W-1:0] dev_rdata
);

   localparam logic [3:0] WAIT_LAST = 4'(BUS_WAIT);

   logic [1:0]        state;
   logic              win;
   logic              rr_ptr;
   logic              we_l;
   logic              err_l;
   logic [ADDR_W-1:0] addr_l;
   logic [DATA_W-1:0] wdata_l;
   logic [DATA_W-1:0] rdata_l;
   logic [3:0]        wait_cnt;

   logic              pick;
   logic              any_req;
   logic              next_ptr;
   logic [ADDR_W-1:0] sel_addr;
   logic [DATA_W-1:0] sel_wdata;
   logic              in_access;
   logic              first_access;
   logic              in_resp;
   logic [1:0]        win_oh;

   dev_bus_rr_pick u_pick (
      .req (m_req),
      .ptr (rr_ptr),
      .win (pick),
      .any (any_req)
   );

   assign sel_addr  = pick ? m1_addr  : m0_addr;
   assign sel_wdata = pick ? m1_wdata : m0_wdata;

`ifdef DEV_BUS_LOCK_EN
   assign next_ptr = (m_lock[win] && m_req[win]) ? win : ~win;
`else
   logic unused_lock;
   assign unused_lock = ^m_lock;
   assign next_ptr    = ~win;
`endif

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state    <= ST_IDLE;
         win      <= 1'b0;
         rr_ptr   <= 1'b0;
         we_l     <= 1'b0;
         err_l    <= 1'b0;
         addr_l   <= '0;
         wdata_l  <= '0;
         rdata_l  <= '0;
         wait_cnt <= '0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (any_req) begin
                  win      <= pick;
                  addr_l   <= sel_addr;
                  wdata_l  <= sel_wdata;
                  we_l     <= m_we[pick];
                  err_l    <= !addr_hit(64'(sel_addr));
                  wait_cnt <= '0;
                  state    <= ST_ACCESS;
               end
            end
            ST_ACCESS: begin
               if (wait_cnt == WAIT_LAST) begin
                  // Errored or write accesses never return bridge data.
                  rdata_l <= (err_l || we_l) ? '0 : dev_rdata;
                  state   <= ST_RESP;
               end else begin
                  wait_cnt <= wait_cnt + 4'd1;
               end
            end
            ST_RESP: begin
               rr_ptr <= next_ptr;
               state  <= ST_IDLE;
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

   // Outputs decode straight from registered state so reset clears them asynchronously.
   assign in_access    = (state == ST_ACCESS);
   assign first_access = in_access && (wait_cnt == 4'd0);
   assign in_resp      = (state == ST_RESP);
   assign win_oh       = win ? 2'b10 : 2'b01;

   assign m_gnt     = first_access ? win_oh : 2'b00;
   assign m_ack     = in_resp ? win_oh : 2'b00;
   assign m_rdata   = in_resp ? rdata_l : '0;
   assign m_err     = in_resp && err_l;
   assign dev_addr  = in_access ? addr_l : '0;
   assign dev_wdata = in_access ? wdata_l : '0;
   assign dev_we    = first_access && we_l && !err_l;

endmodule

// File: tb/tb_dev_bus_arbiter.sv
// Bench for dev_bus_arbiter: two instances (BUS_WAIT 0 and 3) checked every cycle
// against a transaction-phase model, plus directed literal checks and random traffic.
module tb_dev_bus_arbiter;

   localparam int BW0 = 0;
   localparam int BW1 = 3;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        reset_n   [2];
   logic [1:0]  m_req     [2];
   logic [1:0]  m_we      [2];
   logic [1:0]  m_lock    [2];
   logic [31:0] m0_addr   [2];
   logic [31:0] m1_addr   [2];
   logic [31:0] m0_wdata  [2];
   logic [31:0] m1_wdata  [2];
   logic [31:0] dev_rdata [2];
   logic [1:0]  m_gnt     [2];
   logic [1:0]  m_ack     [2];
   logic [31:0] m_rdata   [2];
   logic        m_err     [2];
   logic [31:0] dev_addr  [2];
   logic [31:0] dev_wdata [2];
   logic        dev_we    [2];

   dev_bus_arbiter #(.ADDR_W(32), .DATA_W(32), .BUS_WAIT(BW0)) u_dut0 (
      .clk(clk), .reset_n(reset_n[0]), .m_req(m_req[0]), .m_we(m_we[0]),
      .m0_addr(m0_addr[0]), .m1_addr(m1_addr[0]), .m0_wdata(m0_wdata[0]), .m1_wdata(m1_wdata[0]),
      .m_lock(m_lock[0]), .m_gnt(m_gnt[0]), .m_ack(m_ack[0]), .m_rdata(m_rdata[0]),
      .m_err(m_err[0]), .dev_addr(dev_addr[0]), .dev_wdata(dev_wdata[0]), .dev_we(dev_we[0]),
      .dev_rdata(dev_rdata[0])
   );

   dev_bus_arbiter #(.ADDR_W(32), .DATA_W(32), .BUS_WAIT(BW1)) u_dut1 (
      .clk(clk), .reset_n(reset_n[1]), .m_req(m_req[1]), .m_we(m_we[1]),
      .m0_addr(m0_addr[1]), .m1_addr(m1_addr[1]), .m0_wdata(m0_wdata[1]), .m1_wdata(m1_wdata[1]),
      .m_lock(m_lock[1]), .m_gnt(m_gnt[1]), .m_ack(m_ack[1]), .m_rdata(m_rdata[1]),
      .m_err(m_err[1]), .dev_addr(dev_addr[1]), .dev_wdata(dev_wdata[1]), .dev_we(dev_we[1]),
      .dev_rdata(dev_rdata[1])
   );

   // Model: ph = cycles since the request was accepted (0 = idle);
   // ACCESS spans ph 1..1+bw, the ack cycle is ph 2+bw.
   int          ph   [2];
   bit          rr   [2];
   bit          wn   [2];
   bit          we_l [2];
   bit          er_l [2];
   logic [31:0] a_l  [2];
   logic [31:0] d_l  [2];
   logic [31:0] rd_l [2];

   int vectors     = 0;
   int miscompares = 0;

   function automatic int bwof(int i);
      return (i == 0) ? BW0 : BW1;
   endfunction

   function automatic bit in_dev(logic [31:0] a);
      return ((a >= 32'h7F00) && (a <= 32'h7F0B)) || ((a >= 32'h7F10) && (a <= 32'h7F1B));
   endfunction

   function automatic logic [1:0] oh(bit w);
      return w ? 2'b10 : 2'b01;
   endfunction

   function automatic logic [31:0] rand_addr();
      case ($urandom_range(0, 6))
         0: return 32'h7F00 + 32'($urandom_range(0, 11));
         1: return 32'h7F10 + 32'($urandom_range(0, 11));
         2: return 32'h7EFF;
         3: return 32'h7F0C;
         4: return 32'h7F1C;
         5: return 32'h7F0F;
         default: return $urandom;
      endcase
   endfunction

   task automatic chk(string name, int i, logic [63:0] act, logic [63:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s dut%0d: got %0h expected %0h at %0t", name, i, act, exp, $time);
      end
   endtask

   task automatic advance(int i);
      int          bw = bwof(i);
      logic [1:0]  rq = m_req[i];
      if (!reset_n[i]) begin
         ph[i] = 0;
         rr[i] = 1'b0;
      end else if (ph[i] == 0) begin
         if (rq != 2'b00) begin
            wn[i]   = rq[rr[i]] ? rr[i] : !rr[i];
            a_l[i]  = wn[i] ? m1_addr[i] : m0_addr[i];
            d_l[i]  = wn[i] ? m1_wdata[i] : m0_wdata[i];
            we_l[i] = m_we[i][wn[i]];
            er_l[i] = !in_dev(a_l[i]);
            ph[i]   = 1;
         end
      end else if (ph[i] <= 1 + bw) begin
         if (ph[i] == 1 + bw) rd_l[i] = (er_l[i] || we_l[i]) ? 32'h0 : dev_rdata[i];
         ph[i]++;
      end else begin
`ifdef DEV_BUS_LOCK_EN
         rr[i] = (m_lock[i][wn[i]] && rq[wn[i]]) ? wn[i] : !wn[i];
`else
         rr[i] = !wn[i];
`endif
         ph[i] = 0;
      end
   endtask

   task automatic compare(int i);
      int bw  = bwof(i);
      bit acc = (ph[i] >= 1) && (ph[i] <= 1 + bw);
      bit rsp = (ph[i] == 2 + bw);
      chk("m_gnt",     i, 64'(m_gnt[i]),     64'((ph[i] == 1) ? oh(wn[i]) : 2'b00));
      chk("m_ack",     i, 64'(m_ack[i]),     64'(rsp ? oh(wn[i]) : 2'b00));
      chk("m_rdata",   i, 64'(m_rdata[i]),   64'(rsp ? rd_l[i] : 32'h0));
      chk("m_err",     i, 64'(m_err[i]),     64'(rsp && er_l[i]));
      chk("dev_addr",  i, 64'(dev_addr[i]),  64'(acc ? a_l[i] : 32'h0));
      chk("dev_wdata", i, 64'(dev_wdata[i]), 64'(acc ? d_l[i] : 32'h0));
      chk("dev_we",    i, 64'(dev_we[i]),    64'((ph[i] == 1) && we_l[i] && !er_l[i]));
   endtask

   task automatic tick();
      for (int i = 0; i < 2; i++) advance(i);
      @(negedge clk);
      for (int i = 0; i < 2; i++) compare(i);
   endtask

   task automatic put(int i, int m, bit req, bit we, logic [31:0] a, logic [31:0] d);
      m_req[i][m] = req;
      m_we[i][m]  = we;
      if (m == 0) begin
         m0_addr[i]  = a;
         m0_wdata[i] = d;
      end else begin
         m1_addr[i]  = a;
         m1_wdata[i] = d;
      end
   endtask

   task automatic idle_all();
      for (int i = 0; i < 2; i++) begin
         m_req[i]  = 2'b00;
         m_lock[i] = 2'b00;
      end
   endtask

   task automatic stim(int i);
      int bw = bwof(i);
      dev_rdata[i] = $urandom;
      m_lock[i]    = 2'($urandom);
      for (int m = 0; m < 2; m++) begin
         bit acked = (ph[i] == 2 + bw) && (int'(wn[i]) == m);
         bit owned = (ph[i] >= 1) && (ph[i] < 2 + bw) && (int'(wn[i]) == m);
         if (acked) begin
            if ($urandom_range(0, 1) == 1) put(i, m, 1'b1, 1'($urandom), rand_addr(), $urandom);
            else m_req[i][m] = 1'b0;
         end else if (!m_req[i][m]) begin
            if ($urandom_range(0, 2) == 0) put(i, m, 1'b1, 1'($urandom), rand_addr(), $urandom);
         end else if (owned && $urandom_range(0, 9) == 0) begin
            m_req[i][m] = 1'b0;
         end
      end
   endtask

   initial begin
      for (int i = 0; i < 2; i++) begin
         reset_n[i] = 1'b0;
         m_req[i] = 2'b00; m_we[i] = 2'b00; m_lock[i] = 2'b00;
         m0_addr[i] = 32'h0; m1_addr[i] = 32'h0; m0_wdata[i] = 32'h0; m1_wdata[i] = 32'h0;
         dev_rdata[i] = 32'h0;
         ph[i] = 0; rr[i] = 1'b0; wn[i] = 1'b0; we_l[i] = 1'b0; er_l[i] = 1'b0;
         a_l[i] = 32'h0; d_l[i] = 32'h0; rd_l[i] = 32'h0;
      end
      repeat (2) @(negedge clk);
      for (int i = 0; i < 2; i++) begin
         compare(i);
         chk("reset_gnt", i, 64'(m_gnt[i]), 64'h0);
         chk("reset_we",  i, 64'(dev_we[i]), 64'h0);
      end
      reset_n[0] = 1'b1;
      reset_n[1] = 1'b1;
      tick();

      // m0 write into window 0, no wait states
      put(0, 0, 1'b1, 1'b1, 32'h7F04, 32'h1234);
      tick();
      chk("t1_gnt",   0, 64'(m_gnt[0]), 64'h1);
      chk("t1_we",    0, 64'(dev_we[0]), 64'h1);
      chk("t1_addr",  0, 64'(dev_addr[0]), 64'h7F04);
      chk("t1_wdata", 0, 64'(dev_wdata[0]), 64'h1234);
      tick();
      chk("t1_ack",   0, 64'(m_ack[0]), 64'h1);
      chk("t1_err",   0, 64'(m_err[0]), 64'h0);
      idle_all();
      tick();

      // m1 read from window 1
      put(0, 1, 1'b1, 1'b0, 32'h7F14, 32'h0);
      dev_rdata[0] = 32'hCAFE;
      tick();
      chk("t2_gnt",   0, 64'(m_gnt[0]), 64'h2);
      tick();
      chk("t2_ack",   0, 64'(m_ack[0]), 64'h2);
      chk("t2_rdata", 0, 64'(m_rdata[0]), 64'hCAFE);
      chk("t2_err",   0, 64'(m_err[0]), 64'h0);
      idle_all();
      tick();

      // both requesting continuously: m0, m1, m0
      put(0, 0, 1'b1, 1'b0, 32'h7F00, 32'h0);
      put(0, 1, 1'b1, 1'b0, 32'h7F10, 32'h0);
      tick();
      chk("t3_gnt_a", 0, 64'(m_gnt[0]), 64'h1);
      repeat (3) tick();
      chk("t3_gnt_b", 0, 64'(m_gnt[0]), 64'h2);
      repeat (3) tick();
      chk("t3_gnt_c", 0, 64'(m_gnt[0]), 64'h1);
      tick();
      idle_all();
      tick();

      // write outside both windows
      put(0, 0, 1'b1, 1'b1, 32'h8000, 32'h5555);
      tick();
      chk("t4_gnt",   0, 64'(m_gnt[0]), 64'h1);
      chk("t4_we",    0, 64'(dev_we[0]), 64'h0);
      tick();
      chk("t4_ack",   0, 64'(m_ack[0]), 64'h1);
      chk("t4_err",   0, 64'(m_err[0]), 64'h1);
      chk("t4_rdata", 0, 64'(m_rdata[0]), 64'h0);
      idle_all();
      tick();

      // three wait states: data sampled on the last ACCESS cycle
      put(1, 0, 1'b1, 1'b0, 32'h7F00, 32'h0);
      dev_rdata[1] = 32'h1111;
      tick();
      chk("t5_gnt", 1, 64'(m_gnt[1]), 64'h1);
      repeat (3) tick();
      chk("t5_noack", 1, 64'(m_ack[1]), 64'h0);
      dev_rdata[1] = 32'hBEEF;
      tick();
      chk("t5_ack",   1, 64'(m_ack[1]), 64'h1);
      chk("t5_rdata", 1, 64'(m_rdata[1]), 64'hBEEF);
      idle_all();
      dev_rdata[1] = 32'h2222;
      tick();

      // reset during a write access
      put(1, 0, 1'b1, 1'b1, 32'h7F08, 32'hA5A5);
      tick();
      chk("t6_we_on", 1, 64'(dev_we[1]), 64'h1);
      reset_n[1] = 1'b0;
      m_req[1]   = 2'b00;
      #1;
      chk("t6_we_async",   1, 64'(dev_we[1]), 64'h0);
      chk("t6_addr_async", 1, 64'(dev_addr[1]), 64'h0);
      tick();
      reset_n[1] = 1'b1;
      tick();
      put(1, 0, 1'b1, 1'b0, 32'h7F01, 32'h0);
      put(1, 1, 1'b1, 1'b0, 32'h7F11, 32'h0);
      tick();
      chk("t6_rr_reset", 1, 64'(m_gnt[1]), 64'h1);
      idle_all();
      repeat (6) tick();

`ifdef DEV_BUS_LOCK_EN
      // rr pointer is at m1 here; after m1's slot a locked m0 keeps winning
      put(0, 0, 1'b1, 1'b0, 32'h7F02, 32'h0);
      put(0, 1, 1'b1, 1'b0, 32'h7F12, 32'h0);
      m_lock[0] = 2'b01;
      tick();
      repeat (3) tick();
      chk("lock_gnt_a", 0, 64'(m_gnt[0]), 64'h1);
      repeat (3) tick();
      chk("lock_gnt_b", 0, 64'(m_gnt[0]), 64'h1);
      idle_all();
      repeat (6) tick();
`endif

      for (int c = 0; c < 4000; c++) begin
         for (int i = 0; i < 2; i++) stim(i);
         tick();
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
